// File: rtl/uart_pkg.sv
// Shared UART baud-timing constants, frame config type and frame-length helper.
// Pure definitions; no latency or backpressure of its own.
package uart_pkg;

  localparam int unsigned DEFAULT_DIV = 5207;
  localparam int unsigned MIN_DIV     = 4;

  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd9;

  typedef enum logic {
    MODE_RX = 1'b0,
    MODE_TX = 1'b1
  } chan_mode_e;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       parity_en;
    logic       stop2;
  } frame_cfg_t;

  // start + data + optional parity + one stop; TX may add a second stop bit
  function automatic logic [3:0] frame_len(input frame_cfg_t cfg, input chan_mode_e mode);
    logic [3:0] len;
    len = 4'd2 + cfg.data_bits + {3'b000, cfg.parity_en};
    if (mode == MODE_TX) begin
      len = len + {3'b000, cfg.stop2};
    end
    return len;
  endfunction

endpackage

// File: rtl/uart_bps_gen_if.sv
// Control/status bundle between the UART shift logic, register path and bit-timing generator.
// Strobes are one-cycle pulses; there is no backpressure on any signal.
interface uart_bps_gen_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 4
);

  logic [DIV_W-1:0] div_cfg;
  logic             div_load;
  logic [3:0]       data_bits;
  logic             parity_en;
  logic             stop2;
  logic             rx_flag;
  logic             tx_flag;

  logic             rx_bit_flag;
  logic [CNT_W-1:0] rx_bit_cnt;
  logic             rx_frame_done;
  logic             tx_bit_flag;
  logic [CNT_W-1:0] tx_bit_cnt;
  logic             tx_frame_done;
  logic             div_pending;
  logic             cfg_err;

  modport master (
    output div_cfg, div_load, data_bits, parity_en, stop2, rx_flag, tx_flag,
    input  rx_bit_flag, rx_bit_cnt, rx_frame_done,
    input  tx_bit_flag, tx_bit_cnt, tx_frame_done,
    input  div_pending, cfg_err
  );

  modport slave (
    input  div_cfg, div_load, data_bits, parity_en, stop2, rx_flag, tx_flag,
    output rx_bit_flag, rx_bit_cnt, rx_frame_done,
    output tx_bit_flag, tx_bit_cnt, tx_frame_done,
    output div_pending, cfg_err
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Per-channel baud counter, bit strobe, bit index and frame-done; RX strobes mid-bit, TX at bit start.
// Strobe one cycle after the counter hit (RX: half+1 after flag rise, TX: 1); no backpressure.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int         DIV_W = 16,
  parameter int         CNT_W = 4,
  parameter chan_mode_e MODE  = MODE_RX
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flag_i,
  input  logic [DIV_W-1:0] div_act_i,
  input  frame_cfg_t       cfg_i,
  output logic             bit_flag_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic             frame_done_o
);

  logic             flag_q;
  logic [3:0]       len_q, len_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] half;
  logic [CNT_W-1:0] last_idx_q, last_idx_d;
  logic             hit;

  always_comb begin
    // frame shape is frozen on the first cycle the flag is seen high
    len_d = len_q;
    if (flag_i && !flag_q) begin
      len_d = frame_len(cfg_i, MODE);
    end
    last_idx_d = CNT_W'(len_d) - CNT_W'(1);
    last_idx_q = CNT_W'(len_q) - CNT_W'(1);

    half     = div_act_i >> 1;
    hit      = (MODE == MODE_RX) ? (cnt_q == half) : (cnt_q == '0);
    strobe_d = flag_i && hit;
    done_d   = strobe_d && (bit_cnt_q == last_idx_d);

    cnt_d = '0;
    if (flag_i && (cnt_q != div_act_i - DIV_W'(1))) begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    bit_cnt_d = bit_cnt_q;
    if (!flag_i) begin
      bit_cnt_d = '0;
    end else if (strobe_q) begin
      bit_cnt_d = (bit_cnt_q == last_idx_q) ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flag_q    <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      flag_q    <= flag_i;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  assign bit_flag_o   = strobe_q;
  assign bit_cnt_o    = bit_cnt_q;
  assign frame_done_o = done_q;

endmodule

// File: rtl/uart_bps_gen.sv
// UART RX/TX bit-timing generator with a runtime divisor applied only between frames.
// cfg_err and div_pending update one cycle after div_load; no backpressure.
module uart_bps_gen
  import uart_pkg::*;
#(
  parameter int          DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
  parameter int          CNT_W       = 4
) (
  input logic           sclk_i,
  input logic           rst_i,
  uart_bps_gen_if.slave bps_if
);

  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_bad, accept, idle;
  frame_cfg_t       cfg;

  always_comb begin
    cfg.data_bits = bps_if.data_bits;
    cfg.parity_en = bps_if.parity_en;
    cfg.stop2     = bps_if.stop2;

    cfg_bad = (bps_if.div_cfg < DIV_W'(MIN_DIV)) ||
              (bps_if.data_bits < DATA_BITS_MIN) ||
              (bps_if.data_bits > DATA_BITS_MAX);
    accept    = bps_if.div_load && !cfg_bad;
    cfg_err_d = bps_if.div_load && cfg_bad;
    idle      = !bps_if.rx_flag && !bps_if.tx_flag;

    shadow_d  = accept ? bps_if.div_cfg : shadow_q;
    pending_d = pending_q;
    div_act_d = div_act_q;
    // a load on an idle edge bypasses the shadow so pending never shows
    if (idle) begin
      pending_d = 1'b0;
      if (accept) begin
        div_act_d = bps_if.div_cfg;
      end else if (pending_q) begin
        div_act_d = shadow_q;
      end
    end else if (accept) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      div_act_q <= DIV_W'(DEFAULT_DIV);
      shadow_q  <= '0;
      pending_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      div_act_q <= div_act_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bps_if.div_pending = pending_q;
  assign bps_if.cfg_err     = cfg_err_q;

  uart_bit_timer #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W),
    .MODE  (MODE_RX)
  ) u_rx_timer (
    .clk_i        (sclk_i),
    .rst_i        (rst_i),
    .flag_i       (bps_if.rx_flag),
    .div_act_i    (div_act_q),
    .cfg_i        (cfg),
    .bit_flag_o   (bps_if.rx_bit_flag),
    .bit_cnt_o    (bps_if.rx_bit_cnt),
    .frame_done_o (bps_if.rx_frame_done)
  );

  uart_bit_timer #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W),
    .MODE  (MODE_TX)
  ) u_tx_timer (
    .clk_i        (sclk_i),
    .rst_i        (rst_i),
    .flag_i       (bps_if.tx_flag),
    .div_act_i    (div_act_q),
    .cfg_i        (cfg),
    .bit_flag_o   (bps_if.tx_bit_flag),
    .bit_cnt_o    (bps_if.tx_bit_cnt),
    .frame_done_o (bps_if.tx_frame_done)
  );

endmodule

// File: tb/tb_uart_bps_gen.sv
// Bench for uart_bps_gen: stimulus pushes expected strobes/errors into queues, a negedge monitor pops and compares.
module tb_uart_bps_gen;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;

  typedef struct {
    int cyc;
    int idx;
    int done;
  } ev_t;

  ev_t rx_q[$];
  ev_t tx_q[$];
  int  err_q[$];
  ev_t mon_ev;
  int  mon_err;

  uart_bps_gen_if #(.DIV_W(16), .CNT_W(4)) bus ();

  uart_bps_gen #(
    .DIV_W       (16),
    .DEFAULT_DIV (5207),
    .CNT_W       (4)
  ) dut (
    .sclk_i (sclk),
    .rst_i  (rst),
    .bps_if (bus.slave)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected strobes of one channel; RX samples mid-bit, TX at bit start
  task automatic push_frame(input bit is_tx, input int start, input int div, input int len, input int n);
    ev_t e;
    int  first;
    first = is_tx ? start + 1 : start + div / 2 + 1;
    for (int i = 0; i < n; i++) begin
      e.cyc  = first + i * div;
      e.idx  = i % len;
      e.done = (e.idx == len - 1) ? 1 : 0;
      if (is_tx) tx_q.push_back(e);
      else       rx_q.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic load_div(input int d);
    bus.div_cfg  = 16'(d);
    bus.div_load = 1'b1;
    @(negedge sclk);
    bus.div_load = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_bit_flag"},   int'(bus.rx_bit_flag),   0);
    chk({tag, "_rx_bit_cnt"},    int'(bus.rx_bit_cnt),    0);
    chk({tag, "_rx_frame_done"}, int'(bus.rx_frame_done), 0);
    chk({tag, "_tx_bit_flag"},   int'(bus.tx_bit_flag),   0);
    chk({tag, "_tx_bit_cnt"},    int'(bus.tx_bit_cnt),    0);
    chk({tag, "_tx_frame_done"}, int'(bus.tx_frame_done), 0);
    chk({tag, "_div_pending"},   int'(bus.div_pending),   0);
    chk({tag, "_cfg_err"},       int'(bus.cfg_err),       0);
  endtask

  always @(negedge sclk) begin
    if (!rst) begin
      if (bus.rx_bit_flag) begin
        chk("rx_strobe_expected", int'(rx_q.size() > 0), 1);
        if (rx_q.size() > 0) begin
          mon_ev = rx_q.pop_front();
          chk("rx_strobe_cycle", cyc, mon_ev.cyc);
          chk("rx_bit_cnt", int'(bus.rx_bit_cnt), mon_ev.idx);
          chk("rx_frame_done", int'(bus.rx_frame_done), mon_ev.done);
        end
      end else if (bus.rx_frame_done) begin
        chk("rx_done_needs_strobe", int'(bus.rx_bit_flag), 1);
      end

      if (bus.tx_bit_flag) begin
        chk("tx_strobe_expected", int'(tx_q.size() > 0), 1);
        if (tx_q.size() > 0) begin
          mon_ev = tx_q.pop_front();
          chk("tx_strobe_cycle", cyc, mon_ev.cyc);
          chk("tx_bit_cnt", int'(bus.tx_bit_cnt), mon_ev.idx);
          chk("tx_frame_done", int'(bus.tx_frame_done), mon_ev.done);
        end
      end else if (bus.tx_frame_done) begin
        chk("tx_done_needs_strobe", int'(bus.tx_bit_flag), 1);
      end

      if (bus.cfg_err) begin
        chk("cfg_err_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) begin
          mon_err = err_q.pop_front();
          chk("cfg_err_cycle", cyc, mon_err);
        end
      end
    end
  end

  initial begin
    bus.div_cfg   = '0;
    bus.div_load  = 1'b0;
    bus.data_bits = 4'd8;
    bus.parity_en = 1'b0;
    bus.stop2     = 1'b0;
    bus.rx_flag   = 1'b0;
    bus.tx_flag   = 1'b0;

    idle_cycles(2);
    chk_all_zero("reset");
    rst = 1'b0;
    idle_cycles(1);

    // Default divisor 5207, 8N1 RX frame: 2604 to first sample, then 5207 apart
    c0 = cyc;
    bus.rx_flag = 1'b1;
    push_frame(1'b0, c0, 5207, 10, 10);
    idle_cycles(2604 + 9 * 5207 + 3);
    bus.rx_flag = 1'b0;
    idle_cycles(2);

    // Idle load of 8 applies at once; TX 7E2 frame, then a back-to-back restart
    bus.data_bits = 4'd7;
    load_div(8);
    chk("pending_after_idle_load", int'(bus.div_pending), 0);
    bus.parity_en = 1'b1;
    bus.stop2     = 1'b1;
    c0 = cyc;
    bus.tx_flag = 1'b1;
    push_frame(1'b1, c0, 8, 11, 13);
    idle_cycles(5);
    bus.data_bits = 4'd5;
    bus.parity_en = 1'b0;
    bus.stop2     = 1'b0;
    idle_cycles(95);
    bus.tx_flag = 1'b0;
    bus.data_bits = 4'd8;
    idle_cycles(2);

    // Load during an RX frame waits for idle, then the next frame uses 16
    c0 = cyc;
    bus.rx_flag = 1'b1;
    push_frame(1'b0, c0, 8, 10, 10);
    idle_cycles(20);
    bus.div_cfg  = 16'd16;
    bus.div_load = 1'b1;
    idle_cycles(1);
    bus.div_load = 1'b0;
    chk("pending_mid_frame", int'(bus.div_pending), 1);
    idle_cycles(59);
    bus.rx_flag = 1'b0;
    idle_cycles(1);
    chk("pending_cleared_idle", int'(bus.div_pending), 0);
    c0 = cyc;
    bus.rx_flag = 1'b1;
    push_frame(1'b0, c0, 16, 10, 3);
    idle_cycles(45);
    bus.rx_flag = 1'b0;
    idle_cycles(2);

    // Rejected loads: divisor below 4, then data_bits of 4
    bus.div_cfg  = 16'd3;
    bus.div_load = 1'b1;
    err_q.push_back(cyc + 1);
    idle_cycles(1);
    bus.div_load = 1'b0;
    chk("pending_after_bad_div", int'(bus.div_pending), 0);
    idle_cycles(2);
    bus.div_cfg   = 16'd12;
    bus.data_bits = 4'd4;
    bus.div_load  = 1'b1;
    err_q.push_back(cyc + 1);
    idle_cycles(1);
    bus.div_load  = 1'b0;
    bus.data_bits = 4'd8;
    chk("pending_after_bad_bits", int'(bus.div_pending), 0);
    idle_cycles(2);
    c0 = cyc;
    bus.tx_flag = 1'b1;
    push_frame(1'b1, c0, 16, 10, 2);
    idle_cycles(20);
    bus.tx_flag = 1'b0;
    idle_cycles(2);

    // RX abort at bit 4, then a clean restart from index 0
    load_div(8);
    c0 = cyc;
    bus.rx_flag = 1'b1;
    push_frame(1'b0, c0, 8, 10, 5);
    idle_cycles(40);
    bus.rx_flag = 1'b0;
    idle_cycles(1);
    chk("abort_rx_bit_cnt", int'(bus.rx_bit_cnt), 0);
    chk("abort_rx_bit_flag", int'(bus.rx_bit_flag), 0);
    idle_cycles(1);
    c0 = cyc;
    bus.rx_flag = 1'b1;
    push_frame(1'b0, c0, 8, 10, 3);
    idle_cycles(24);
    bus.rx_flag = 1'b0;
    idle_cycles(2);

    // Concurrent RX/TX at 10 with a pending load, then asynchronous reset mid-frame
    load_div(10);
    c0 = cyc;
    bus.rx_flag = 1'b1;
    bus.tx_flag = 1'b1;
    push_frame(1'b0, c0, 10, 10, 2);
    push_frame(1'b1, c0, 10, 10, 3);
    idle_cycles(5);
    bus.div_cfg  = 16'd20;
    bus.div_load = 1'b1;
    idle_cycles(1);
    bus.div_load = 1'b0;
    chk("pending_concurrent", int'(bus.div_pending), 1);
    idle_cycles(19);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    bus.rx_flag = 1'b0;
    bus.tx_flag = 1'b0;
    @(negedge sclk);
    rst = 1'b0;
    idle_cycles(2);
    c0 = cyc;
    bus.rx_flag = 1'b1;
    push_frame(1'b0, c0, 5207, 10, 1);
    idle_cycles(2606);
    bus.rx_flag = 1'b0;
    idle_cycles(3);

    chk("rx_queue_drained", rx_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_bps_gen.md
Name: uart_bps_gen

Overview:
Parametrised successor to the fixed-rate UART bit-timing generator. Produces independent RX and TX bit-strobe timing from one shared divisor. The divisor is runtime-programmable, and frame length follows a configurable data width, parity and stop-bit count. Sits between the UART RX/TX shift logic and the control/register path; owns all baud timing in the SPI-flash/multiboot debug UART.

Parameters:
DIV_W, 16, width of the divisor and baud counters
DEFAULT_DIV, 5207, active divisor after reset (9600 Bd at 50 MHz); must be >= 4
CNT_W, 4, width of the bit index outputs (max frame 13 bits)

Ports:
sclk  in  1  system clock
rst  in  1  asynchronous, active-high reset
div_cfg  in  DIV_W  requested divisor (clocks per bit)
div_load  in  1  one-cycle strobe; request to load div_cfg
data_bits  in  4  data bits per frame, legal 5..9
parity_en  in  1  1 = one parity bit after data
stop2  in  1  1 = two stop bits (TX only)
rx_flag  in  1  RX frame active (held high by RX logic for the whole frame)
tx_flag  in  1  TX frame active
rx_bit_flag  out  1  one-cycle mid-bit sample strobe
rx_bit_cnt  out  CNT_W  index of the RX bit being timed (0 = start bit)
rx_frame_done  out  1  one-cycle pulse on the final RX sample strobe
tx_bit_flag  out  1  one-cycle bit-start strobe
tx_bit_cnt  out  CNT_W  index of the TX bit being timed
tx_frame_done  out  1  one-cycle pulse on the final TX bit strobe
div_pending  out  1  a loaded divisor is waiting to be applied
cfg_err  out  1  one-cycle pulse when div_load is rejected

Behaviour:
- Reset: all outputs 0; div_act = DEFAULT_DIV; both baud counters and bit counters 0; no divisor pending.
- Divisor load:
  - div_load with div_cfg < 4 or data_bits outside 5..9: rejected, cfg_err pulses next cycle, state unchanged.
  - Otherwise div_cfg is captured into a shadow register and div_pending = 1.
  - The shadow is copied to div_act on the first edge at which rx_flag = 0 and tx_flag = 0. This can be the same edge as the load, in which case div_pending never rises.
  - A new div_load while pending overwrites the shadow.
  - div_act never changes mid-frame.
- Frame config: data_bits, parity_en and stop2 are latched per channel on the edge where that channel's flag is first sampled high. Changes mid-frame have no effect.
  - rx_len = 1 + data_bits + parity_en + 1.
  - tx_len = rx_len + stop2.
- Baud counter (per channel):
  - Held at 0 while the flag is low.
  - While the flag is high, it increments each edge and wraps from div_act-1 to 0, so the bit period is exactly div_act clocks.
  - half = div_act >> 1 (floor).
- rx_bit_flag: registered; set for one cycle on the edge after rx_cnt == half with rx_flag high.
  - First strobe is half+1 cycles after rx_flag rises; subsequent strobes are every div_act cycles.
- tx_bit_flag: registered; set for one cycle on each edge where tx_cnt == 0 and tx_flag is high.
  - First strobe is 1 cycle after tx_flag rises; subsequent strobes are every div_act cycles.
- Bit counters:
  - During a strobe cycle, *_bit_cnt holds the index of that bit; it increments on the edge after the strobe.
  - When a strobe occurs with *_bit_cnt == len-1: *_frame_done is high in the same cycle as that strobe, and the counter returns to 0 after it.
  - If the flag is still high after that, the counter keeps timing (back-to-back frames); indices restart at 0.
- Abort: flag dropping mid-frame clears the baud counter, bit counter and any strobe on the next edge; no frame_done.
- Simultaneous events: RX and TX are fully independent. A div_load on the same edge as a flag fall is applied on the next idle edge.
- Reset mid-frame: immediate asynchronous clear to reset values; the pending shadow is discarded.

Decomposition:
- Package uart_pkg: DEFAULT_DIV, MIN_DIV = 4, data_bits legal range, frame-length function.
- One sub-module, uart_bit_timer, instantiated twice (RX mode strobes at half, TX mode strobes at 0). It contains the baud counter, strobe, bit counter, frame_done and config latch.
- The top level holds the divisor shadow/apply logic and cfg_err.

Test Plan:
1. Reset, rx_flag high with default div 5207, 8N1 -> first rx_bit_flag 2604 cycles after rise, then every 5207; rx_frame_done coincides with strobe at rx_bit_cnt = 9.
2. div_cfg = 8 loaded while idle, tx_flag high, data_bits = 7, parity_en = 1, stop2 = 1 -> tx strobes at cycles 1, 9, 17, ...; tx_frame_done at index 10 (cycle 81).
3. div_load = 16 during an active RX frame at div 8 -> div_pending = 1, frame finishes at 8-cycle spacing; div_act = 16 on the first idle edge; next frame spacing 16.
4. div_cfg = 3, or data_bits = 4 -> cfg_err one-cycle pulse, div_act unchanged, div_pending = 0.
5. rx_flag dropped at bit 4 (div 8) -> strobes stop, rx_bit_cnt = 0 next cycle, no rx_frame_done; reassert -> first strobe 5 cycles later at index 0.
6. RX and TX run concurrently at div 10, with rst asserted mid-frame -> all outputs 0 asynchronously; div_act = DEFAULT_DIV after release.
